// File: rtl/cpu_pkg.sv
// Shared pipeline types for the ID-stage hazard logic: forward-select codes,
// the unused-operand marker and the E/M/W shadow scoreboard entry.
package cpu_pkg;

    // Scoreboard register-address width; narrower REG_AW values are zero-extended.
    localparam int SB_AW = 5;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] wreg;
        logic [1:0]       tnew;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // One pipeline step closer to the result; a ready value stays ready.
    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-writer lookup over the E/M/W scoreboard for one source register.
// Register 0 never matches; E beats M beats W.
module sb_match
    import cpu_pkg::*;
(
    input  logic [SB_AW-1:0] r,
    input  sb_entry_t        e_ent,
    input  sb_entry_t        m_ent,
    input  sb_entry_t        w_ent,
    output logic             hit,
    output logic [1:0]       stage,
    output logic [1:0]       tnew
);

    function automatic logic writes(input sb_entry_t ent, input logic [SB_AW-1:0] reg_a);
        return ent.valid && (ent.wreg == reg_a) && (reg_a != '0);
    endfunction

    always_comb begin
        hit   = 1'b0;
        stage = FWD_RF;
        tnew  = 2'd0;
        if (writes(e_ent, r)) begin
            hit   = 1'b1;
            stage = FWD_E;
            tnew  = e_ent.tnew;
        end else if (writes(m_ent, r)) begin
            hit   = 1'b1;
            stage = FWD_M;
            tnew  = m_ent.tnew;
        end else if (writes(w_ent, r)) begin
            hit   = 1'b1;
            stage = FWD_W;
            tnew  = w_ent.tnew;
        end
    end

endmodule

// File: rtl/cmp_hazard_ctrl.sv
// ID-stage stall/forward/branch-resolve control for the branch comparator.
// Optional CMP_HAZARD_PERF_EN adds free-running stall and taken-branch counters.
module cmp_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [1:0]        d_tuse_rs,
    input  logic [1:0]        d_tuse_rt,
    input  logic [REG_AW-1:0] d_wreg,
    input  logic [1:0]        d_tnew,
    input  logic              d_branch,
    input  logic              d_bne,
    input  logic              cmp_equal,
    output logic              stall,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              br_taken
`ifdef CMP_HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       br_taken_cnt
`endif
);

    sb_entry_t e_q, m_q, w_q;
    sb_entry_t e_d, m_d, w_d;

    logic [SB_AW-1:0] rs_ext, rt_ext, wreg_ext;

    logic       rs_hit, rt_hit;
    logic [1:0] rs_stage, rt_stage;
    logic [1:0] rs_tnew, rt_tnew;
    logic       hz_rs, hz_rt;

    assign rs_ext   = SB_AW'(d_rs);
    assign rt_ext   = SB_AW'(d_rt);
    assign wreg_ext = SB_AW'(d_wreg);

    sb_match u_match_rs (
        .r     (rs_ext),
        .e_ent (e_q),
        .m_ent (m_q),
        .w_ent (w_q),
        .hit   (rs_hit),
        .stage (rs_stage),
        .tnew  (rs_tnew)
    );

    sb_match u_match_rt (
        .r     (rt_ext),
        .e_ent (e_q),
        .m_ent (m_q),
        .w_ent (w_q),
        .hit   (rt_hit),
        .stage (rt_stage),
        .tnew  (rt_tnew)
    );

    // A producer blocks only if its value will not exist by the time this operand is read.
    always_comb begin
        hz_rs = rs_hit && (d_tuse_rs != TUSE_NONE) && (rs_tnew > d_tuse_rs);
        hz_rt = rt_hit && (d_tuse_rt != TUSE_NONE) && (rt_tnew > d_tuse_rt);
        stall = d_valid && (hz_rs || hz_rt);
    end

    // Operands not yet ready come from the RF here and get forwarded downstream later.
    always_comb begin
        fwd_rs_sel = FWD_RF;
        fwd_rt_sel = FWD_RF;
        if (d_valid && rs_hit && (rs_tnew == 2'd0)) begin
            fwd_rs_sel = rs_stage;
        end
        if (d_valid && rt_hit && (rt_tnew == 2'd0)) begin
            fwd_rt_sel = rt_stage;
        end
    end

    always_comb begin
        br_taken = d_valid && d_branch && !stall && (cmp_equal ^ d_bne);
    end

    always_comb begin
        e_d       = SB_EMPTY;
        e_d.valid = d_valid && !stall && (d_wreg != '0);
        e_d.wreg  = wreg_ext;
        e_d.tnew  = d_tnew;

        m_d      = e_q;
        m_d.tnew = tnew_step(e_q.tnew);

        w_d      = m_q;
        w_d.tnew = tnew_step(m_q.tnew);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= SB_EMPTY;
            m_q <= SB_EMPTY;
            w_q <= SB_EMPTY;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef CMP_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] br_taken_cnt_q, br_taken_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q + (stall ? 32'd1 : 32'd0);
        br_taken_cnt_d = br_taken_cnt_q + (br_taken ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= 32'd0;
            br_taken_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_hazard_ctrl.sv
// Bench for cmp_hazard_ctrl: directed pipeline scenarios with literal expectations,
// then random instruction streams against an in-flight-write model (CMP_HAZARD_PERF_EN aware).
module tb_cmp_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wreg;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_branch, d_bne, cmp_equal;
  logic       stall, br_taken;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef CMP_HAZARD_PERF_EN
  logic [31:0] stall_cnt, br_taken_cnt;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  cmp_hazard_ctrl #(.REG_AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wreg     (d_wreg),
    .d_tnew     (d_tnew),
    .d_branch   (d_branch),
    .d_bne      (d_bne),
    .cmp_equal  (cmp_equal),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .br_taken   (br_taken)
`ifdef CMP_HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .br_taken_cnt (br_taken_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each accepted writer is remembered with the cycle it enters E; its age gives
  // the stage (0=E,1=M,2=W) and enter+tnew the cycle its result exists.
  typedef struct {
    int rg;
    int enter;
    int tnew;
  } wr_t;

  wr_t inflight[$];
  int  cyc = 0;
  int  exp_stall_cnt = 0;
  int  exp_br_cnt = 0;

  function automatic void lookup(input int r, output bit hit, output int age, output int rem);
    hit = 0;
    age = 0;
    rem = 0;
    if (r == 0) return;
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      int a;
      a = cyc - inflight[i].enter;
      if (a >= 0 && a <= 2 && inflight[i].rg == r) begin
        hit = 1;
        age = a;
        rem = inflight[i].enter + inflight[i].tnew - cyc;
        if (rem < 0) rem = 0;
        return;
      end
    end
  endfunction

  function automatic void eval(output int st, output int frs, output int frt, output int bt);
    bit h1, h2, hz1, hz2;
    int a1, a2, r1, r2;
    lookup(int'(d_rs), h1, a1, r1);
    lookup(int'(d_rt), h2, a2, r2);
    hz1 = h1 && (d_tuse_rs != 2'd3) && (r1 > int'(d_tuse_rs));
    hz2 = h2 && (d_tuse_rt != 2'd3) && (r2 > int'(d_tuse_rt));
    st  = (d_valid && (hz1 || hz2)) ? 1 : 0;
    frs = (d_valid && h1 && r1 == 0) ? a1 + 1 : 0;
    frt = (d_valid && h2 && r2 == 0) ? a2 + 1 : 0;
    bt  = (d_valid && d_branch && st == 0 && (cmp_equal ^ d_bne)) ? 1 : 0;
  endfunction

  task automatic model_advance();
    int st, frs, frt, bt;
    eval(st, frs, frt, bt);
    if (reset) begin
      inflight.delete();
      exp_stall_cnt = 0;
      exp_br_cnt = 0;
    end else begin
      if (d_valid && st == 0 && d_wreg != 5'd0)
        inflight.push_back('{rg: int'(d_wreg), enter: cyc + 1, tnew: int'(d_tnew)});
      exp_stall_cnt += st;
      exp_br_cnt += bt;
      while (inflight.size() > 0 && (cyc + 1 - inflight[0].enter) > 2)
        void'(inflight.pop_front());
    end
    cyc++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) check_model();
  end

  task automatic check_model();
    int st, frs, frt, bt;
    eval(st, frs, frt, bt);
    chk("model stall", int'(stall), st);
    chk("model fwd_rs_sel", int'(fwd_rs_sel), frs);
    chk("model fwd_rt_sel", int'(fwd_rt_sel), frt);
    chk("model br_taken", int'(br_taken), bt);
`ifdef CMP_HAZARD_PERF_EN
    chk("model stall_cnt", int'(stall_cnt), exp_stall_cnt);
    chk("model br_taken_cnt", int'(br_taken_cnt), exp_br_cnt);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] wreg, input logic [1:0] tnew,
                       input logic br, input logic bne, input logic eq);
    d_valid   = v;
    d_rs      = rs;
    d_rt      = rt;
    d_tuse_rs = tu_rs;
    d_tuse_rt = tu_rt;
    d_wreg    = wreg;
    d_tnew    = tnew;
    d_branch  = br;
    d_bne     = bne;
    cmp_equal = eq;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic expect_now(input string nm, input int st, input int frs, input int frt, input int bt);
    @(negedge clk);
    #1;
    chk({nm, " stall"}, int'(stall), st);
    chk({nm, " fwd_rs"}, int'(fwd_rs_sel), frs);
    chk({nm, " fwd_rt"}, int'(fwd_rt_sel), frt);
    chk({nm, " br_taken"}, int'(br_taken), bt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    drive_idle();
    tick();
    chk_en = 1;
    tick();
    reset = 1'b0;
    expect_now("reset", 0, 0, 0, 0);
    tick();

    // load then dependent branch
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_now("lw issue", 0, 0, 0, 0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    expect_now("lw-beq c1", 1, 0, 0, 0);
    tick();
    expect_now("lw-beq c2", 1, 0, 0, 0);
    tick();
    expect_now("lw-beq c3", 0, 3, 0, 1);
    tick();
    drive_idle();
`ifdef CMP_HAZARD_PERF_EN
    @(negedge clk);
    #1;
    chk("perf stall_cnt", int'(stall_cnt), 2);
    chk("perf br_taken_cnt", int'(br_taken_cnt), 1);
`endif
    tick();

    // ALU then dependent bne
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd7, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    expect_now("add-bne c1", 1, 0, 0, 0);
    tick();
    expect_now("add-bne c2", 0, 2, 2, 0);
    tick();

    // register 0 never hazards
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    expect_now("r0 beq", 0, 0, 0, 1);
    tick();

    // youngest writer wins
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'd9, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    expect_now("youngest", 0, 1, 0, 0);
    tick();

    // ALU then E-stage consumer: no stall, value forwarded later
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 2'd1, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_now("alu-tuse1", 0, 0, 0, 0);
    tick();

    // both operands hazard: one shared stall
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd6, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    expect_now("both c1", 1, 0, 0, 0);
    tick();
    expect_now("both c2", 0, 3, 2, 0);
    tick();

    // reset during a load-induced stall
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    expect_now("rst-stall c1", 1, 0, 0, 0);
    tick();
    reset = 1'b0;
    drive_idle();
    expect_now("rst-stall c2", 0, 0, 0, 0);
    tick();

    // random instruction streams
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive(logic'($urandom_range(0, 9) < 8),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)));
      tick();
    end
    reset = 1'b0;
    drive_idle();
    tick();
    tick();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
